// File: rtl/mat_mult_ctrl.sv
// 4x4 matrix-multiply controller: operand/result buffers, issue sequencer and
// result tag pipeline for one external 4-term dot-product datapath. Optional err_80 via MAT_CTRL_ERR_EN.
module mat_mult_ctrl #(
  parameter int WIDTH_A_80 = 9,
  parameter int WIDTH_B_80 = 8,
  parameter int WIDTH_SUM  = 11,
  parameter int DP_LATENCY = 1
) (
  input  logic                  clk_80,
  input  logic                  rst_80,
  input  logic                  wr_en_80,
  input  logic                  wr_sel_80,
  input  logic [3:0]            wr_addr_80,
  input  logic [WIDTH_A_80-1:0] wr_data_80,
  input  logic                  start_80,
  input  logic [3:0]            rd_addr_80,
  output logic [WIDTH_SUM-1:0]  rd_data_80,
  output logic                  busy_80,
  output logic                  done_80,
  output logic [WIDTH_A_80-1:0] dp_a0_80,
  output logic [WIDTH_A_80-1:0] dp_a1_80,
  output logic [WIDTH_A_80-1:0] dp_a2_80,
  output logic [WIDTH_A_80-1:0] dp_a3_80,
  output logic [WIDTH_B_80-1:0] dp_b0_80,
  output logic [WIDTH_B_80-1:0] dp_b1_80,
  output logic [WIDTH_B_80-1:0] dp_b2_80,
  output logic [WIDTH_B_80-1:0] dp_b3_80,
  input  logic [WIDTH_SUM-1:0]  dp_ab_80
`ifdef MAT_CTRL_ERR_EN
  ,
  output logic                  err_80
`endif
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_e;

  state_e                state_q, state_d;
  logic [3:0]            k_q, k_d;
  logic [1:0]            drain_q, drain_d;

  logic [WIDTH_A_80-1:0] a_q [4][4];
  logic [WIDTH_B_80-1:0] b_q [4][4];
  logic [WIDTH_SUM-1:0]  c_q [16];

  logic [DP_LATENCY-1:0] tag_vld_q;
  logic [3:0]            tag_k_q [DP_LATENCY];

  logic                  accept_q_free;
  logic                  wr_ok;
  logic                  start_ok;
  logic                  issue;
  logic                  drain_last;
  logic [1:0]            row;
  logic [1:0]            col;

  // Host access is only honoured while the sequencer is parked.
  assign accept_q_free = (state_q == S_IDLE) || (state_q == S_DONE);
  assign wr_ok         = wr_en_80 && accept_q_free;
  assign start_ok      = start_80 && accept_q_free;
  assign issue         = (state_q == S_RUN);
  assign drain_last    = (drain_q == 2'(DP_LATENCY - 1));
  assign row           = k_q[3:2];
  assign col           = k_q[1:0];

  // NOTE: combinational next-state uses blocking '=' with every output defaulted
  // first, so no path leaves a signal unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    drain_d = drain_q;
    unique case (state_q)
      S_IDLE: begin
        if (start_ok) begin
          state_d = S_RUN;
          k_d     = '0;
        end
      end
      S_RUN: begin
        k_d = k_q + 4'd1;
        if (k_q == 4'd15) begin
          state_d = S_DRAIN;
          drain_d = '0;
        end
      end
      S_DRAIN: begin
        drain_d = drain_q + 2'd1;
        if (drain_last) state_d = S_DONE;
      end
      S_DONE: begin
        if (start_ok) begin
          state_d = S_RUN;
          k_d     = '0;
        end else begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_80 or negedge rst_80) begin
    if (!rst_80) begin
      state_q <= S_IDLE;
      k_q     <= '0;
      drain_q <= '0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      drain_q <= drain_d;
    end
  end

  // NOTE: the buffers are small register arrays that must read back as zero
  // after reset, so they sit in the async reset branch rather than in a RAM.
  always_ff @(posedge clk_80 or negedge rst_80) begin
    if (!rst_80) begin
      for (int r = 0; r < 4; r++) begin
        for (int c = 0; c < 4; c++) begin
          a_q[r][c] <= '0;
          b_q[r][c] <= '0;
        end
      end
    end else if (wr_ok) begin
      if (wr_sel_80) b_q[wr_addr_80[3:2]][wr_addr_80[1:0]] <= wr_data_80[WIDTH_B_80-1:0];
      else           a_q[wr_addr_80[3:2]][wr_addr_80[1:0]] <= wr_data_80;
    end
  end

  // Tag stage 0 is loaded on the issue edge; the last stage lines up with dp_ab_80.
  always_ff @(posedge clk_80 or negedge rst_80) begin
    if (!rst_80) begin
      for (int t = 0; t < DP_LATENCY; t++) begin
        tag_vld_q[t] <= 1'b0;
        tag_k_q[t]   <= '0;
      end
    end else begin
      tag_vld_q[0] <= issue;
      tag_k_q[0]   <= k_q;
      for (int t = 1; t < DP_LATENCY; t++) begin
        tag_vld_q[t] <= tag_vld_q[t-1];
        tag_k_q[t]   <= tag_k_q[t-1];
      end
    end
  end

  always_ff @(posedge clk_80 or negedge rst_80) begin
    if (!rst_80) begin
      for (int e = 0; e < 16; e++) c_q[e] <= '0;
    end else if (tag_vld_q[DP_LATENCY-1]) begin
      c_q[tag_k_q[DP_LATENCY-1]] <= dp_ab_80;
    end
  end

  assign rd_data_80 = c_q[rd_addr_80];
  assign busy_80    = (state_q == S_RUN) || (state_q == S_DRAIN);
  assign done_80    = (state_q == S_DONE);

  assign dp_a0_80 = issue ? a_q[row][0] : '0;
  assign dp_a1_80 = issue ? a_q[row][1] : '0;
  assign dp_a2_80 = issue ? a_q[row][2] : '0;
  assign dp_a3_80 = issue ? a_q[row][3] : '0;
  assign dp_b0_80 = issue ? b_q[0][col] : '0;
  assign dp_b1_80 = issue ? b_q[1][col] : '0;
  assign dp_b2_80 = issue ? b_q[2][col] : '0;
  assign dp_b3_80 = issue ? b_q[3][col] : '0;

`ifdef MAT_CTRL_ERR_EN
  logic err_q;

  // Sticky protocol error; an accepted start is the only non-reset clear.
  always_ff @(posedge clk_80 or negedge rst_80) begin
    if (!rst_80)                                err_q <= 1'b0;
    else if (start_ok)                          err_q <= 1'b0;
    else if (busy_80 && (wr_en_80 || start_80)) err_q <= 1'b1;
  end

  assign err_80 = err_q;
`endif

endmodule

// File: doc/mat_mult_ctrl.md
MAT_MULT_CTRL -- requirements
Module: mat_mult_ctrl

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
- WIDTH_A_80, 9, A element width
- WIDTH_B_80, 8, B element width
- WIDTH_SUM, 11, dot-product result width
- DP_LATENCY, 1, datapath input-to-dp_ab_80 latency in clk_80 edges, legal 1..4

REQ-002 Ports SHALL be, one per line: name, direction, width, meaning.
- clk_80, in, 1, single clock, rising edge
- rst_80, in, 1, asynchronous active-low reset
- wr_en_80, in, 1, operand write strobe
- wr_sel_80, in, 1, 0=A buffer, 1=B buffer
- wr_addr_80, in, 4, {row[1:0],col[1:0]}
- wr_data_80, in, WIDTH_A_80, write data; B uses low WIDTH_B_80 bits
- start_80, in, 1, start request
- rd_addr_80, in, 4, result index {i,j}
- rd_data_80, out, WIDTH_SUM, C[rd_addr_80], combinational read
- busy_80, out, 1, high in RUN and DRAIN
- done_80, out, 1, one-cycle completion pulse
- dp_a0_80..dp_a3_80, out, WIDTH_A_80 each, datapath A operands
- dp_b0_80..dp_b3_80, out, WIDTH_B_80 each, datapath B operands
- dp_ab_80, in, WIDTH_SUM, datapath registered result
- err_80, out, 1, present only with MAT_CTRL_ERR_EN

REQ-003 The block SHALL use one clock; reset SHALL be asynchronous, active-low, on rst_80.

Function
REQ-004 The block SHALL hold 4x4 buffers A (WIDTH_A_80), B (WIDTH_B_80) and C (WIDTH_SUM), and SHALL compute C = A x B using one external 4-term dot-product datapath.
REQ-005 States SHALL be IDLE, RUN, DRAIN, DONE.
- IDLE->RUN on start_80
- RUN->DRAIN after issue 15
- DRAIN->DONE after DP_LATENCY cycles
- DONE->IDLE, or DONE->RUN if start_80
REQ-006 In IDLE and DONE, wr_en_80 SHALL write wr_data_80 to the selected buffer at wr_addr_80 on the clock edge.
REQ-007 In RUN the block SHALL issue exactly one dot product per cycle, index k=0..15, with i=k[3:2], j=k[1:0]:
- dp_aN_80 = A[i][N]
- dp_bN_80 = B[N][j]
REQ-008 Outside RUN, all dp_a*/dp_b* outputs SHALL be zero.
REQ-009 A DP_LATENCY-deep tag pipeline (valid, k) SHALL track issues; when a valid tag exits, C[k] SHALL be written with dp_ab_80 on that edge.
REQ-010 Counting the edge that samples start_80 as edge 0:
- issues occur at edges 1..16
- C[15] is written at edge 17+DP_LATENCY-1
- done_80 is high for exactly the following cycle
REQ-011 Simultaneous wr_en_80 and start_80 in IDLE SHALL perform the write, and the written value SHALL be used by the run.
REQ-012 While busy_80=1, wr_en_80 and start_80 SHALL be ignored.
REQ-013 rd_data_80 SHALL be readable at any time; during a run it returns the mix of old and new C entries written so far.
REQ-014 The block SHALL NOT correct operand values, round or saturate; the datapath owns all arithmetic.

Reset
REQ-015 While rst_80=0, asynchronously:
- state=IDLE, k=0, tags invalid
- A, B, C cleared to 0
- busy_80=0, done_80=0, err_80=0, dp outputs 0
REQ-016 Reset asserted mid-run SHALL abort the run with no done_80 pulse.

Configuration
REQ-017 With MAT_CTRL_ERR_EN defined, err_80 SHALL set sticky on any wr_en_80 or start_80 while busy_80=1, and clear only on reset or on an accepted start_80.
REQ-018 Without MAT_CTRL_ERR_EN, port err_80 and its logic SHALL be absent; behaviour is otherwise identical.

Verification
Benches SHALL use a stub datapath, dp_ab_80 = sum of dp_a*_80 registered, with DP_LATENCY=1, unless stated.
REQ-019 A[i][k]=4i+k, start -> C[0]=6, C[5]=22, C[15]=54; done_80 pulses in the cycle after edge 17.
REQ-020 Stub summing dp_b*_80; B[k][j]=4k+j -> C[3]=36, C[14]=32.
REQ-021 start_80 pulsed at RUN cycle 5, and a write to A[0][0]=7 during RUN -> no restart, A[0][0] unchanged; err_80=1 with MAT_CTRL_ERR_EN.
REQ-022 rst_80 low at RUN issue k=8 -> busy_80=0 immediately, all C=0, no done_80 pulse.
REQ-023 start_80 held in the DONE cycle -> second run begins with no IDLE gap; DP_LATENCY=3 -> done_80 pulses after edge 19.
